// File: rtl/sonar_varredura_uc_pkg.sv
// Shared definitions for the sonar sweep controller: FSM state codes
// (also used directly as the debug display value) and the invalid-state marker.
package sonar_varredura_uc_pkg;

    typedef logic [3:0] estado_t;

    localparam estado_t ST_INICIAL            = 4'h0;
    localparam estado_t ST_PREPARACAO         = 4'h1;
    localparam estado_t ST_ESPERA_SERVO       = 4'h2;
    localparam estado_t ST_MEDIR              = 4'h3;
    localparam estado_t ST_ESPERA_MEDIDA      = 4'h4;
    localparam estado_t ST_TRANSMISSAO        = 4'h5;
    localparam estado_t ST_ESPERA_TRANSMISSAO = 4'h6;
    localparam estado_t ST_PROXIMA_POSICAO    = 4'h7;
    localparam estado_t ST_PARADO             = 4'h8;

    localparam logic [3:0] DB_INVALIDO = 4'hF;

    // Codes above ST_PARADO are unreachable in normal operation.
    function automatic logic estado_valido(input estado_t e);
        return (e <= ST_PARADO);
    endfunction

endpackage

// File: rtl/sonar_temporizador.sv
// Loadable down-counter shared by the servo settle wait and the echo timeout.
// Saturates at zero so a late decrement never wraps around.
module sonar_temporizador #(
    parameter int W_TIMER = 25
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carrega,
    input  logic [W_TIMER-1:0] valor,
    input  logic               decrementa,
    output logic               zero
);

    logic [W_TIMER-1:0] contagem_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            contagem_reg <= '0;
        end else if (carrega) begin
            contagem_reg <= valor;
        end else if (decrementa && (contagem_reg != '0)) begin
            contagem_reg <= contagem_reg - W_TIMER'(1);
        end
    end

    assign zero = (contagem_reg == '0);

endmodule

// File: rtl/sonar_varredura_uc.sv
// Sonar sweep controller: walks the servo through its positions in ping-pong
// order, and at each one settles, measures (with echo timeout) and transmits.
module sonar_varredura_uc
    import sonar_varredura_uc_pkg::*;
#(
    parameter int N_POSICOES     = 8,
    parameter int W_POS          = 3,
    parameter int T_ASSENTAMENTO = 25_000_000,
    parameter int T_TIMEOUT      = 1_500_000,
    parameter int W_TIMER        = 25
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ligar,
    input  logic             fim_medida,
    input  logic             fim_transmissao,
    output logic             zera,
    output logic             medir_distancia,
    output logic             transmitir,
    output logic [W_POS-1:0] posicao,
    output logic             timeout,
    output logic             pronto,
    output logic [3:0]       db_estado
);

    localparam logic [W_POS-1:0]   POS_MAX     = W_POS'(N_POSICOES - 1);
    localparam logic [W_TIMER-1:0] CARGA_SERVO = W_TIMER'(T_ASSENTAMENTO - 1);
    localparam logic [W_TIMER-1:0] CARGA_ECO   = W_TIMER'(T_TIMEOUT - 1);

    estado_t          estado_reg, estado_next;
    logic [W_POS-1:0] posicao_reg, posicao_next;
    logic             subida_reg, subida_next;
    logic             timeout_reg;

    logic               timer_carrega;
    logic               timer_decrementa;
    logic [W_TIMER-1:0] timer_valor;
    logic               timer_zero;

    sonar_temporizador #(
        .W_TIMER (W_TIMER)
    ) u_temporizador (
        .clock      (clock),
        .reset      (reset),
        .carrega    (timer_carrega),
        .valor      (timer_valor),
        .decrementa (timer_decrementa),
        .zero       (timer_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_reg <= ST_INICIAL;
        end else begin
            estado_reg <= estado_next;
        end
    end

    // fim_medida takes priority over an expiring timer in espera_medida.
    always_comb begin
        estado_next = ST_INICIAL;
        case (estado_reg)
            ST_INICIAL:            estado_next = ligar ? ST_PREPARACAO : ST_INICIAL;
            ST_PREPARACAO:         estado_next = ST_ESPERA_SERVO;
            ST_ESPERA_SERVO:       estado_next = timer_zero ? ST_MEDIR : ST_ESPERA_SERVO;
            ST_MEDIR:              estado_next = ST_ESPERA_MEDIDA;
            ST_ESPERA_MEDIDA:      estado_next = (fim_medida || timer_zero) ? ST_TRANSMISSAO
                                                                            : ST_ESPERA_MEDIDA;
            ST_TRANSMISSAO:        estado_next = ST_ESPERA_TRANSMISSAO;
            ST_ESPERA_TRANSMISSAO: estado_next = fim_transmissao ? ST_PROXIMA_POSICAO
                                                                 : ST_ESPERA_TRANSMISSAO;
            ST_PROXIMA_POSICAO:    estado_next = ligar ? ST_ESPERA_SERVO : ST_PARADO;
            ST_PARADO:             estado_next = ligar ? ST_PREPARACAO : ST_PARADO;
            default:               estado_next = ST_INICIAL;
        endcase
    end

    always_comb begin
        zera             = 1'b0;
        medir_distancia  = 1'b0;
        transmitir       = 1'b0;
        pronto           = 1'b0;
        timer_carrega    = 1'b0;
        timer_decrementa = 1'b0;
        timer_valor      = CARGA_SERVO;
        db_estado        = estado_valido(estado_reg) ? estado_reg : DB_INVALIDO;
        case (estado_reg)
            ST_INICIAL:         zera = 1'b1;
            ST_PREPARACAO: begin
                zera          = 1'b1;
                timer_carrega = 1'b1;
            end
            ST_ESPERA_SERVO:    timer_decrementa = 1'b1;
            ST_MEDIR: begin
                medir_distancia = 1'b1;
                timer_carrega   = 1'b1;
                timer_valor     = CARGA_ECO;
            end
            ST_ESPERA_MEDIDA:   timer_decrementa = 1'b1;
            ST_TRANSMISSAO:     transmitir = 1'b1;
            ST_PROXIMA_POSICAO: timer_carrega = ligar;
            ST_PARADO:          pronto = 1'b1;
            default: ;
        endcase
    end

    // Ping-pong stepping: each endpoint reverses direction and moves one step away.
    always_comb begin
        posicao_next = posicao_reg;
        subida_next  = subida_reg;
        if (subida_reg) begin
            if (posicao_reg != POS_MAX) begin
                posicao_next = posicao_reg + W_POS'(1);
            end else begin
                subida_next  = 1'b0;
                posicao_next = posicao_reg - W_POS'(1);
            end
        end else begin
            if (posicao_reg != '0) begin
                posicao_next = posicao_reg - W_POS'(1);
            end else begin
                subida_next  = 1'b1;
                posicao_next = posicao_reg + W_POS'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            posicao_reg <= '0;
            subida_reg  <= 1'b1;
            timeout_reg <= 1'b0;
        end else begin
            if (estado_reg == ST_PROXIMA_POSICAO) begin
                posicao_reg <= posicao_next;
                subida_reg  <= subida_next;
            end
            if (estado_reg == ST_MEDIR) begin
                timeout_reg <= 1'b0;
            end else if ((estado_reg == ST_ESPERA_MEDIDA) && !fim_medida && timer_zero) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign posicao = posicao_reg;
    assign timeout = timeout_reg;

endmodule
